inst_fetch_queue: RTL and testbench

//   Instruction fetch stage upstream of the single-cycle core's Splitter/decode.

---
 rtl/inst_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one imem read at a time and buffers {pc, inst}.
// Optional build macro IFQ_STATS_EN adds fetch_cnt/flush_cnt statistics outputs.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d, pc_q, pc_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          push, pop;

  always_comb begin
    push       = (state_q == S_REQ) && imem_ack && !redirect_valid;
    pop        = valid_q && inst_ready && !redirect_valid;
    state_d    = state_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    data_d     = data_q;
    head       = mem_q[rd_ptr_q];

    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // A request in flight cannot be withdrawn, so a redirect without ack parks in DROP.
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          state_d = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          if (count_d < DEPTH_C) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q + 32'd4;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d   = (state_d != S_IDLE);
    valid_d = (count_d != '0);
    // The word being pushed becomes the head when it lands at the new read pointer.
    if (push && (rd_ptr_d == wr_ptr_q)) head = {fetch_pc_q, imem_rdata};
    else                                head = mem_q[rd_ptr_d];
    if (valid_d) {pc_d, data_d} = head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC_A;
      addr_q     <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {fetch_pc_q, imem_rdata};
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_pc    = pc_q;

`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push)           fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a latency-programmable memory model feeds expected
// {pc, inst} pairs into a queue that is compared against every pop.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFQ_STATS_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  int          lat = 0;
  int          wcnt = 0;
  logic        stale = 1'b0;
  logic [31:0] stale_addr = '0;
  logic [31:0] exp_pc = '0;
  int          arm = 0;
  logic [31:0] arm_addr = '0;
  logic [31:0] arm_pc = '0;
  logic        arm_hit = 1'b0;
  logic        want_first = 1'b0;
  logic [31:0] first_pc = '0;
  int          fetch_exp = 0;
  int          flush_exp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic clear_model();
    sb_q.delete();
    wcnt = 0; stale = 1'b0; exp_pc = '0; arm = 0; want_first = 1'b0;
    fetch_exp = 0; flush_exp = 0;
    imem_ack = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: check outputs at the negedge, run the memory model, drive inputs for the next posedge.
  task automatic step(input logic rdy, input logic rdr, input logic [31:0] rpc);
    logic        ack_n;
    logic [31:0] dat;
    logic [63:0] e;
    @(negedge clk);
    check_eq("valid", inst_valid, sb_q.size() != 0);
    if (sb_q.size() == DEPTH) check_eq("full_noreq", imem_req, 1'b0);
    if (stale && imem_req) check_eq("drop_addr", imem_addr, stale_addr);
    ack_n = 1'b0;
    if (imem_req) begin
      if (wcnt >= lat) begin ack_n = 1'b1; wcnt = 0; end
      else wcnt++;
    end
    dat = mem_f(imem_addr);
    if (arm == 1 && imem_req && imem_addr == arm_addr && !ack_n && !stale) begin
      rdr = 1'b1; rpc = arm_pc; arm = 0; arm_hit = 1'b1;
    end else if (arm == 2 && ack_n && inst_valid && !stale) begin
      rdr = 1'b1; rdy = 1'b1; rpc = arm_pc; arm = 0; arm_hit = 1'b1;
    end
    if (inst_valid && rdy && !rdr && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("pop_pc", inst_pc, e[63:32]);
      check_eq("pop_data", inst_data, e[31:0]);
      if (want_first) begin
        check_eq("first_pc", inst_pc, first_pc);
        want_first = 1'b0;
      end
    end
    if (ack_n && !stale && !rdr) begin
      check_eq("imem_addr", imem_addr, exp_pc);
      sb_q.push_back({exp_pc, dat});
      exp_pc += 32'd4;
      fetch_exp++;
    end
    if (ack_n) stale = 1'b0;
    if (rdr) begin
      sb_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
      first_pc = exp_pc;
      want_first = 1'b1;
      flush_exp++;
      if (imem_req && !ack_n) begin stale = 1'b1; stale_addr = imem_addr; end
    end
    inst_ready = rdy;
    redirect_valid = rdr;
    redirect_pc = rpc;
    imem_ack = ack_n;
    imem_rdata = ack_n ? dat : 32'hDEAD_BEEF;
  endtask

  initial begin
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", inst_valid, 1'b0);
    check_eq("rst_data", inst_data, 32'h0);
    check_eq("rst_pc", inst_pc, 32'h0);
    do_reset();

    // fill with no consumer, then drain continuously
    lat = 0;
    repeat (20) step(1'b0, 1'b0, '0);
    check_eq("t1_full_valid", inst_valid, 1'b1);
    check_eq("t1_full_req", imem_req, 1'b0);
    repeat (30) step(1'b1, 1'b0, '0);

    // redirect while the 0x10 request waits for a slow ack
    do_reset();
    lat = 2; arm = 1; arm_addr = 32'h10; arm_pc = 32'h40; arm_hit = 1'b0;
    repeat (60) step(1'b1, 1'b0, '0);
    check_eq("t3_hit", arm_hit, 1'b1);
    check_eq("t3_first_seen", want_first, 1'b0);

    // redirect coinciding with ack and pop
    lat = 0;
    repeat (2) step(1'b0, 1'b0, '0);
    arm = 2; arm_pc = 32'h200; arm_hit = 1'b0;
    repeat (10) step(1'b0, 1'b0, '0);
    check_eq("t4_hit", arm_hit, 1'b1);
    repeat (15) step(1'b1, 1'b0, '0);

    // fetch PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (8) step(1'b0, 1'b0, '0);
    repeat (12) step(1'b1, 1'b0, '0);
    check_eq("t5_first_seen", want_first, 1'b0);
`ifdef IFQ_STATS_EN
    check_eq("fetch_cnt", fetch_cnt, fetch_exp);
    check_eq("flush_cnt", flush_cnt, flush_exp);
`endif

    // async reset mid-request
    lat = 3; arm_hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0);
      if (imem_req && inst_valid) begin arm_hit = 1'b1; break; end
    end
    check_eq("t6_busy", arm_hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_req", imem_req, 1'b0);
    check_eq("t6_valid", inst_valid, 1'b0);
    check_eq("t6_addr", imem_addr, 32'h0);
    check_eq("t6_pc", inst_pc, 32'h0);
`ifdef IFQ_STATS_EN
    check_eq("t6_fetch_cnt", fetch_cnt, 32'h0);
    check_eq("t6_flush_cnt", flush_cnt, 16'h0);
`endif
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (10) step(1'b1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
